// File: rtl/iir_coef_loader_if.sv
// Coefficient write bus between the control side and the loader.
// The control side drives write requests and the commit strobe; the loader
// answers with ready.
interface iir_coef_loader_if #(
    parameter int Width = 16
);
    logic             wr_valid;
    logic             wr_ready;
    logic [3:0]       wr_addr;
    logic [Width-1:0] wr_data;
    logic             commit;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        output commit,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        input  commit,
        output wr_ready
    );
endinterface

// File: rtl/iir_coef_loader.sv
// Coefficient staging and commit controller for the 16-bit IIR filter.
// Writes land in shadow registers; a commit copies them into the active
// a/b buses in one step and holds the filter in reset for Flush_Len cycles
// so its delay lines and pipeline never mix old and new coefficients.
module iir_coef_loader #(
    parameter int N_order   = 4,
    parameter int Width     = 16,
    parameter int Flush_Len = 8
) (
    input  logic                     i_clkp,
    input  logic                     i_rstp,
    iir_coef_loader_if.slave         wr_bus,
    output logic [Width*N_order-1:0] o_factor_a,
    output logic [Width*N_order-1:0] o_factor_b,
    output logic                     o_filter_rstn,
    output logic                     o_dirty,
    output logic                     o_busy,
    output logic                     o_err
);

    localparam int         IdxW     = $clog2(N_order);
    localparam int         CntW     = $clog2(Flush_Len) + 1;
    localparam logic [4:0] NumWords = 5'(2 * N_order);

    typedef enum logic [1:0] {
        IDLE,
        SWAP,
        FLUSH
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             run_q;
    logic [CntW-1:0]  cnt_q;
    logic [Width-1:0] sa [N_order];
    logic [Width-1:0] sb [N_order];

    logic             wr_fire;
    logic             addr_ok;
    logic             wr_good;

    // run_q keeps ready low for the first cycle after reset release, since
    // the state register already reads IDLE while reset is held.
    assign wr_bus.wr_ready = run_q && (state_q == IDLE);
    assign wr_fire         = wr_bus.wr_valid && wr_bus.wr_ready;
    assign addr_ok         = ({1'b0, wr_bus.wr_addr} < NumWords);
    assign wr_good         = wr_fire && addr_ok;

    // Next-state decode: a commit only starts a swap when there is something
    // new to swap in, counting a good write arriving in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (run_q && wr_bus.commit && (o_dirty || wr_good)) begin
                    state_d = SWAP;
                end
            end
            SWAP: begin
                state_d = FLUSH;
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, flush counter and the registered filter-reset/busy outputs,
    // which are decoded from the next state so they change on the commit edge.
    always_ff @(posedge i_clkp or posedge i_rstp) begin
        if (i_rstp) begin
            state_q       <= IDLE;
            run_q         <= 1'b0;
            cnt_q         <= '0;
            o_filter_rstn <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            state_q       <= state_d;
            run_q         <= 1'b1;
            o_filter_rstn <= (state_d == IDLE);
            o_busy        <= (state_d != IDLE);
            if (state_q == SWAP) begin
                cnt_q <= CntW'(Flush_Len - 2);
            end else if ((state_q == FLUSH) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Shadow registers; the address bit just above the index picks a or b.
    always_ff @(posedge i_clkp or posedge i_rstp) begin
        if (i_rstp) begin
            for (int i = 0; i < N_order; i++) begin
                sa[i] <= '0;
                sb[i] <= '0;
            end
        end else if (wr_good) begin
            if (wr_bus.wr_addr[IdxW]) begin
                sb[wr_bus.wr_addr[IdxW-1:0]] <= wr_bus.wr_data;
            end else begin
                sa[wr_bus.wr_addr[IdxW-1:0]] <= wr_bus.wr_data;
            end
        end
    end

    // Active coefficient copy and the dirty/error flags, all cleared or
    // refreshed together when leaving SWAP.
    always_ff @(posedge i_clkp or posedge i_rstp) begin
        if (i_rstp) begin
            o_factor_a <= '0;
            o_factor_b <= '0;
            o_dirty    <= 1'b0;
            o_err      <= 1'b0;
        end else if (state_q == SWAP) begin
            for (int i = 0; i < N_order; i++) begin
                o_factor_a[i*Width +: Width] <= sa[i];
                o_factor_b[i*Width +: Width] <= sb[i];
            end
            o_dirty <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            if (wr_good) begin
                o_dirty <= 1'b1;
            end
            if (wr_fire && !addr_ok) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iir_coef_loader.sv
// Directed bench for iir_coef_loader. Commits expected to swap push their
// expected coefficients into a scoreboard; a monitor watches the filter
// reset output, pops an entry on each commit and checks the new buses and
// the flush length.
module tb_iir_coef_loader;

    localparam int NOrder   = 4;
    localparam int Wd       = 16;
    localparam int FlushLen = 8;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        expect_reset;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] factor_a;
    logic [63:0] factor_b;
    logic        filter_rstn;
    logic        dirty;
    logic        busy;
    logic        err;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    iir_coef_loader_if #(.Width(Wd)) wr_if ();

    iir_coef_loader #(
        .N_order   (NOrder),
        .Width     (Wd),
        .Flush_Len (FlushLen)
    ) dut (
        .i_clkp        (clk),
        .i_rstp        (rst),
        .wr_bus        (wr_if.slave),
        .o_factor_a    (factor_a),
        .o_factor_b    (factor_b),
        .o_filter_rstn (filter_rstn),
        .o_dirty       (dirty),
        .o_busy        (busy),
        .o_err         (err)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] a,
                                 input logic [15:0] d, input logic c);
        wr_if.wr_valid = v;
        wr_if.wr_addr  = a;
        wr_if.wr_data  = d;
        wr_if.commit   = c;
        @(posedge clk);
        #1;
        wr_if.wr_valid = 1'b0;
        wr_if.commit   = 1'b0;
    endtask

    task automatic pushExp(input logic [63:0] a, input logic [63:0] b,
                           input logic r);
        exp_t e;
        e.a            = a;
        e.b            = b;
        e.expect_reset = r;
        sb_q.push_back(e);
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_factor_a"}, factor_a, 64'd0);
        checkOutput({tag, "_factor_b"}, factor_b, 64'd0);
        checkOutput({tag, "_filter_rstn"}, 64'(filter_rstn), 64'd0);
        checkOutput({tag, "_dirty"}, 64'(dirty), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_err"}, 64'(err), 64'd0);
        checkOutput({tag, "_wr_ready"}, 64'(wr_if.wr_ready), 64'd0);
    endtask

    // Monitor: a falling filter reset outside reset marks a commit edge.
    initial begin : monitor
        exp_t e;
        logic prev;
        int   low_cnt;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && prev && !filter_rstn) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_commit: filter reset dropped with no commit expected");
                end else begin
                    e = sb_q.pop_front();
                    low_cnt = 1;
                    @(negedge clk);
                    if (!rst) begin
                        checkOutput("swap_factor_a", factor_a, e.a);
                        checkOutput("swap_factor_b", factor_b, e.b);
                        checkOutput("swap_dirty_clear", 64'(dirty), 64'd0);
                    end
                    while (!filter_rstn && !rst && low_cnt < 100) begin
                        low_cnt++;
                        @(negedge clk);
                    end
                    checkOutput("flush_reset_abort", 64'(rst), 64'(e.expect_reset));
                    if (!rst) begin
                        checkOutput("flush_len", 64'(low_cnt), 64'(FlushLen));
                    end
                end
            end
            prev = filter_rstn;
        end
    end

    // Watchdog so the bench never hangs.
    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus.
    initial begin : stimulus
        wr_if.wr_valid = 1'b0;
        wr_if.wr_addr  = 4'd0;
        wr_if.wr_data  = 16'd0;
        wr_if.commit   = 1'b0;

        // Reset values and release.
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst = 1'b0;
        #1;
        checkOutput("release_ready_low", 64'(wr_if.wr_ready), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("release_ready", 64'(wr_if.wr_ready), 64'd1);
        checkOutput("release_filter_rstn", 64'(filter_rstn), 64'd1);

        // Basic write + commit.
        applyStimulus(1'b1, 4'd0, 16'h4000, 1'b0);
        checkOutput("write_dirty", 64'(dirty), 64'd1);
        applyStimulus(1'b1, 4'd4, 16'h2000, 1'b0);
        pushExp(64'h0000_0000_0000_4000, 64'h0000_0000_0000_2000, 1'b0);
        applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1);
        checkOutput("commit_busy", 64'(busy), 64'd1);
        checkOutput("commit_ready", 64'(wr_if.wr_ready), 64'd0);
        waitIdle();
        checkOutput("done_ready", 64'(wr_if.wr_ready), 64'd1);
        checkOutput("done_dirty", 64'(dirty), 64'd0);

        // Commit with nothing dirty is ignored.
        applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1);
        checkOutput("clean_commit_busy", 64'(busy), 64'd0);
        checkOutput("clean_commit_rstn", 64'(filter_rstn), 64'd1);
        @(posedge clk);
        #1;
        checkOutput("clean_commit_rstn2", 64'(filter_rstn), 64'd1);
        checkOutput("clean_commit_a", factor_a, 64'h0000_0000_0000_4000);

        // Write and commit in the same cycle.
        pushExp(64'h0000_0000_0000_4000, 64'h7FFF_0000_0000_2000, 1'b0);
        applyStimulus(1'b1, 4'd7, 16'h7FFF, 1'b1);
        waitIdle();

        // Out-of-range write, then a commit that must be ignored.
        applyStimulus(1'b1, 4'd9, 16'h1234, 1'b0);
        checkOutput("oor_err", 64'(err), 64'd1);
        checkOutput("oor_dirty", 64'(dirty), 64'd0);
        applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1);
        checkOutput("oor_commit_busy", 64'(busy), 64'd0);
        pushExp(64'h0000_0ABC_0000_4000, 64'h7FFF_0000_0000_2000, 1'b0);
        applyStimulus(1'b1, 4'd2, 16'h0ABC, 1'b1);
        waitIdle();
        checkOutput("err_cleared", 64'(err), 64'd0);

        // Write held during FLUSH must wait for IDLE.
        pushExp(64'h0000_0ABC_0000_4000, 64'h7FFF_0000_5555_2000, 1'b0);
        applyStimulus(1'b1, 4'd5, 16'h5555, 1'b1);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_addr  = 4'd6;
        wr_if.wr_data  = 16'h6666;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (!busy) break;
            checkOutput("flush_ready", 64'(wr_if.wr_ready), 64'd0);
            checkOutput("flush_no_write", 64'(dirty), 64'd0);
        end
        checkOutput("held_write_ready", 64'(wr_if.wr_ready), 64'd1);
        @(posedge clk);
        #1;
        wr_if.wr_valid = 1'b0;
        checkOutput("held_write_taken", 64'(dirty), 64'd1);

        // Reset pulsed three cycles into FLUSH.
        pushExp(64'h0000_0ABC_0000_4000, 64'h7FFF_6666_5555_2000, 1'b1);
        applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkResetValues("midflush");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("rerelease_rstn_low", 64'(filter_rstn), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("rerelease_rstn", 64'(filter_rstn), 64'd1);
        checkOutput("rerelease_ready", 64'(wr_if.wr_ready), 64'd1);
        applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1);
        checkOutput("rerelease_clean_commit", 64'(busy), 64'd0);
        pushExp(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000, 1'b0);
        applyStimulus(1'b1, 4'd0, 16'h0001, 1'b1);
        waitIdle();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
